uart_fifo_ptr_ctrl: RTL and testbench
=====================================

// Module: uart_fifo_ptr_ctrl
// PURPOSE
//  Pointer/occupancy controller for the UART TX and RX FIFOs (16550-style).
//  - Sequences write/read addresses into the two FIFO RAMs.
//  - Owns the occupancy counts that white-box coverage samples as tx_fifo_ptr/rx_fifo_ptr.
//  - Derives full/empty, RX overrun, RX trigger-level and RX character-timeout status
//    for the interrupt/LSR logic.
// PARAMETERS
//  DEPTH         16  entries per FIFO; power of 2, >=4
//  AW            4   address width = $clog2(DEPTH)
//  TIMEOUT_CHARS 4   character times of RX inactivity before char_timeout
// PORTS
//  clock        in   1     single clock
//  reset_n      in   1     asynchronous, active-low reset
//  tx_clr       in   1     FCR[2] pulse: flush TX FIFO
//  rx_clr       in   1     FCR[1] pulse: flush RX FIFO
//  rx_trig_sel  in   2     RX trigger: 0->1, 1->4, 2->8, 3->14 entries
//  tx_push      in   1     host write to THR
//  tx_pop       in   1     transmitter takes next char
//  rx_push      in   1     receiver completed a char
//  rx_pop       in   1     host read of RBR
//  lsr_read     in   1     host read of LSR (clears overrun)
//  char_tick    in   1     1-cycle pulse per character time
//  tx_wr_en     out  1     TX RAM write strobe (qualified push)
//  tx_wr_addr   out  AW    TX RAM write address
//  tx_rd_addr   out  AW    TX RAM read address (head entry)
//  rx_wr_en     out  1     RX RAM write strobe
//  rx_wr_addr   out  AW    RX RAM write address
//  rx_rd_addr   out  AW    RX RAM read address
//  tx_fifo_ptr  out  AW+1  TX occupancy 0..DEPTH
//  rx_fifo_ptr  out  AW+1  RX occupancy 0..DEPTH
//  tx_empty / tx_full / rx_empty / rx_full   out  1 each   registered status
//  rx_overrun   out  1     sticky overrun flag
//  rx_trig      out  1     rx_fifo_ptr >= selected trigger level
//  char_timeout out  1     RX character-timeout indication
// BEHAVIOUR
//  Reset:
//  - All pointers and counts = 0; tx_empty = rx_empty = 1.
//  - All other flags = 0; wr_en = 0.
//  Per-FIFO update (same rule for TX and RX), evaluated each clock:
//  - Clear has priority: clr = 1 -> pointers = 0, count = 0 next cycle; push/pop that cycle ignored.
//  - Pop accepted iff count > 0; rd pointer += 1 mod DEPTH.
//  - Push accepted iff count < DEPTH, or a pop is accepted the same cycle; wr pointer += 1 mod DEPTH.
//  - Count: +1 push-only, -1 pop-only, unchanged when both or neither are accepted.
//  - Pointers wrap at DEPTH-1 -> 0. Count never exceeds DEPTH nor underflows.
//  - wr_en is combinational = accepted push; wr_addr is the pre-increment pointer.
//  - rd_addr always addresses the head entry.
//  - Counts, pointers, full (count == DEPTH) and empty (count == 0) are registered; latency 1 cycle.
//  Rejected writes:
//  - TX push when full and no pop: dropped, tx_wr_en = 0, no flag.
//  - RX push when full and no pop: dropped, rx_wr_en = 0, rx_overrun <= 1.
//  rx_overrun:
//  - Cleared by lsr_read, or by rx_clr; set has priority over a same-cycle lsr_read.
//  rx_trig:
//  - Registered compare of the next rx count vs the level; tracks rx_trig_sel changes within 1 cycle.
//  char_timeout counter (3 bits):
//  - Reset to 0 when rx_push, rx_pop or rx_clr occurs, or when the RX FIFO is empty.
//  - Otherwise increments on char_tick, saturating at TIMEOUT_CHARS.
//  - char_timeout = (counter == TIMEOUT_CHARS) && !rx_empty; deasserts the cycle after rx_pop/rx_clr.
//  Reset mid-operation:
//  - Asynchronous; all state returns to reset values immediately. FIFO RAM contents are don't-care.
// STRUCTURE
//  uart_fifo_ctrl_pkg holds:
//  - typedef enum logic [1:0] rx_trig_e {TRIG_1, TRIG_4, TRIG_8, TRIG_14}
//  - function trig_level(rx_trig_e) returning AW+1 bits
//  - default DEPTH/TIMEOUT_CHARS localparams
//  Sub-module uart_fifo_ptr_unit (DEPTH, AW):
//  - Inputs: clr, push, pop. Outputs: wr_en, wr_addr, rd_addr, count, full, empty.
//  - Instantiated twice (TX, RX).
//  Overrun, trigger and timeout logic live in the top.
// TESTING
//  1. Reset, then 16 tx_push -> tx_fifo_ptr = 16, tx_full = 1, tx_wr_addr sequence 0..15;
//     17th push -> tx_wr_en = 0, count stays 16.
//  2. Full TX, push + pop same cycle -> count stays 16, both pointers advance (wr 0 -> 1, rd 0 -> 1).
//  3. 20 pushes + 20 pops interleaved -> pointers wrap 15 -> 0, count returns to 0, tx_empty = 1.
//  4. RX full + rx_push -> rx_overrun = 1, count 16;
//     rx_push with lsr_read same cycle -> stays 1; lsr_read alone -> 0.
//  5. rx_trig_sel = 2, push 7 -> rx_trig = 0; 8th push -> rx_trig = 1 next cycle; switch sel to 3 -> rx_trig = 0.
//  6. RX count 3, no activity, 4 char_tick -> char_timeout = 1; rx_pop -> 0;
//     rx_clr with push same cycle -> count 0; reset_n low mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared types and defaults for the UART FIFO pointer controller.
package uart_fifo_ctrl_pkg;

    localparam int DEF_DEPTH         = 16;
    localparam int DEF_AW            = $clog2(DEF_DEPTH);
    localparam int DEF_TIMEOUT_CHARS = 4;

    typedef enum logic [1:0] {
        TRIG_1,
        TRIG_4,
        TRIG_8,
        TRIG_14
    } rx_trig_e;

    function automatic logic [DEF_AW:0] trig_level(rx_trig_e sel);
        logic [DEF_AW:0] lvl;
        lvl = (DEF_AW+1)'(1);
        unique case (sel)
            TRIG_1:  lvl = (DEF_AW+1)'(1);
            TRIG_4:  lvl = (DEF_AW+1)'(4);
            TRIG_8:  lvl = (DEF_AW+1)'(8);
            TRIG_14: lvl = (DEF_AW+1)'(14);
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_fifo_ptr_unit.sv
// Read/write pointer and occupancy tracking for one FIFO RAM.
module uart_fifo_ptr_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW-1:0] A1       = AW'(1);
    localparam logic [AW:0]   C1       = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          pop_ok, push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign pop_ok  = pop && !clr && (cnt_q != '0);
    assign push_ok = push && !clr && ((cnt_q != FULL_CNT) || pop_ok);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + A1;
            if (pop_ok)  rd_d = rd_q + A1;
            if (push_ok && !pop_ok) cnt_d = cnt_q + C1;
            if (pop_ok && !push_ok) cnt_d = cnt_q - C1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FULL_CNT);
            empty_q <= (cnt_d == '0);
        end
    end

    assign wr_en   = push_ok;
    assign wr_addr = wr_q;
    assign rd_addr = rd_q;
    assign count   = cnt_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/uart_fifo_ptr_ctrl.sv
// TX/RX FIFO pointer control with overrun, trigger-level and char-timeout status.
module uart_fifo_ptr_ctrl
    import uart_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int AW            = $clog2(DEPTH),
    parameter int TIMEOUT_CHARS = DEF_TIMEOUT_CHARS
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          tx_clr,
    input  logic          rx_clr,
    input  logic [1:0]    rx_trig_sel,
    input  logic          tx_push,
    input  logic          tx_pop,
    input  logic          rx_push,
    input  logic          rx_pop,
    input  logic          lsr_read,
    input  logic          char_tick,
    output logic          tx_wr_en,
    output logic [AW-1:0] tx_wr_addr,
    output logic [AW-1:0] tx_rd_addr,
    output logic          rx_wr_en,
    output logic [AW-1:0] rx_wr_addr,
    output logic [AW-1:0] rx_rd_addr,
    output logic [AW:0]   tx_fifo_ptr,
    output logic [AW:0]   rx_fifo_ptr,
    output logic          tx_empty,
    output logic          tx_full,
    output logic          rx_empty,
    output logic          rx_full,
    output logic          rx_overrun,
    output logic          rx_trig,
    output logic          char_timeout
);

    localparam logic [AW:0] C1     = (AW+1)'(1);
    localparam logic [2:0]  TO_MAX = 3'(TIMEOUT_CHARS);

    uart_fifo_ptr_unit #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .clk     (clock),
        .rst_n   (reset_n),
        .clr     (tx_clr),
        .push    (tx_push),
        .pop     (tx_pop),
        .wr_en   (tx_wr_en),
        .wr_addr (tx_wr_addr),
        .rd_addr (tx_rd_addr),
        .count   (tx_fifo_ptr),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    uart_fifo_ptr_unit #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .clk     (clock),
        .rst_n   (reset_n),
        .clr     (rx_clr),
        .push    (rx_push),
        .pop     (rx_pop),
        .wr_en   (rx_wr_en),
        .wr_addr (rx_wr_addr),
        .rd_addr (rx_rd_addr),
        .count   (rx_fifo_ptr),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    logic          ovr_q, ovr_d;
    logic          trig_q, trig_d;
    logic [2:0]    to_q, to_d;
    logic          rx_pop_ok, rx_drop;
    logic [AW:0]   rx_cnt_nxt;

    // A push that the RX unit refused (outside a flush) is an overrun.
    assign rx_pop_ok = rx_pop && !rx_clr && !rx_empty;
    assign rx_drop   = rx_push && !rx_clr && !rx_wr_en;

    always_comb begin
        rx_cnt_nxt = rx_fifo_ptr;
        if (rx_clr)
            rx_cnt_nxt = '0;
        else if (rx_wr_en && !rx_pop_ok)
            rx_cnt_nxt = rx_fifo_ptr + C1;
        else if (!rx_wr_en && rx_pop_ok)
            rx_cnt_nxt = rx_fifo_ptr - C1;
    end

    always_comb begin
        ovr_d = ovr_q;
        if (rx_clr)
            ovr_d = 1'b0;
        else if (rx_drop)
            ovr_d = 1'b1;
        else if (lsr_read)
            ovr_d = 1'b0;

        trig_d = rx_cnt_nxt >=
                 (AW+1)'(trig_level(rx_trig_e'(rx_trig_sel)));

        to_d = to_q;
        if (rx_push || rx_pop || rx_clr || rx_empty)
            to_d = '0;
        else if (char_tick && (to_q != TO_MAX))
            to_d = to_q + 3'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q  <= 1'b0;
            trig_q <= 1'b0;
            to_q   <= '0;
        end else begin
            ovr_q  <= ovr_d;
            trig_q <= trig_d;
            to_q   <= to_d;
        end
    end

    assign rx_overrun   = ovr_q;
    assign rx_trig      = trig_q;
    assign char_timeout = (to_q == TO_MAX) && !rx_empty;

endmodule

// File: tb/tb_uart_fifo_ptr_ctrl.sv
// Randomized and directed checks of uart_fifo_ptr_ctrl against a queue-level model.
module tb_uart_fifo_ptr_ctrl;

    localparam int D = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_clr, rx_clr, tx_push, tx_pop, rx_push, rx_pop;
    logic       lsr_read, char_tick;
    logic [1:0] rx_trig_sel;
    logic       tx_wr_en, rx_wr_en;
    logic [3:0] tx_wr_addr, tx_rd_addr, rx_wr_addr, rx_rd_addr;
    logic [4:0] tx_fifo_ptr, rx_fifo_ptr;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       rx_overrun, rx_trig, char_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: FIFOs as occupancy plus running push/pop totals.
    int m_tcnt, m_tpushes, m_tpops, m_rcnt, m_rpushes, m_rpops, m_idle;
    bit m_ovr, m_trig;
    int lvl [4] = '{1, 4, 8, 14};

    uart_fifo_ptr_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tx_clr       (tx_clr),
        .rx_clr       (rx_clr),
        .rx_trig_sel  (rx_trig_sel),
        .tx_push      (tx_push),
        .tx_pop       (tx_pop),
        .rx_push      (rx_push),
        .rx_pop       (rx_pop),
        .lsr_read     (lsr_read),
        .char_tick    (char_tick),
        .tx_wr_en     (tx_wr_en),
        .tx_wr_addr   (tx_wr_addr),
        .tx_rd_addr   (tx_rd_addr),
        .rx_wr_en     (rx_wr_en),
        .rx_wr_addr   (rx_wr_addr),
        .rx_rd_addr   (rx_rd_addr),
        .tx_fifo_ptr  (tx_fifo_ptr),
        .rx_fifo_ptr  (rx_fifo_ptr),
        .tx_empty     (tx_empty),
        .tx_full      (tx_full),
        .rx_empty     (rx_empty),
        .rx_full      (rx_full),
        .rx_overrun   (rx_overrun),
        .rx_trig      (rx_trig),
        .char_timeout (char_timeout)
    );

    always #5 clock = ~clock;

    function automatic bit tx_pop_acc();
        return tx_pop && !tx_clr && m_tcnt > 0;
    endfunction
    function automatic bit tx_push_acc();
        return tx_push && !tx_clr && (m_tcnt < D || tx_pop_acc());
    endfunction
    function automatic bit rx_pop_acc();
        return rx_pop && !rx_clr && m_rcnt > 0;
    endfunction
    function automatic bit rx_push_acc();
        return rx_push && !rx_clr && (m_rcnt < D || rx_pop_acc());
    endfunction

    task automatic idle();
        tx_clr = 0; rx_clr = 0; tx_push = 0; tx_pop = 0;
        rx_push = 0; rx_pop = 0; lsr_read = 0; char_tick = 0;
    endtask

    task automatic model_zero();
        m_tcnt = 0; m_tpushes = 0; m_tpops = 0;
        m_rcnt = 0; m_rpushes = 0; m_rpops = 0;
        m_idle = 0; m_ovr = 0; m_trig = 0;
    endtask

    // One clock: the model follows the stimulus currently applied.
    task automatic tick();
        bit tpu, tpo, rpu, rpo, drop, quiet_reset;
        tpo = tx_pop_acc();  tpu = tx_push_acc();
        rpo = rx_pop_acc();  rpu = rx_push_acc();
        drop = rx_push && !rx_clr && !rpu;
        quiet_reset = rx_push || rx_pop || rx_clr || (m_rcnt == 0);
        @(posedge clock);
        if (tx_clr) begin
            m_tcnt = 0; m_tpushes = 0; m_tpops = 0;
        end else begin
            m_tcnt += int'(tpu) - int'(tpo);
            m_tpushes += int'(tpu); m_tpops += int'(tpo);
        end
        if (quiet_reset) m_idle = 0;
        else if (char_tick && m_idle < 4) m_idle++;
        if (rx_clr) begin
            m_rcnt = 0; m_rpushes = 0; m_rpops = 0; m_ovr = 0;
        end else begin
            m_rcnt += int'(rpu) - int'(rpo);
            m_rpushes += int'(rpu); m_rpops += int'(rpo);
            if (drop) m_ovr = 1;
            else if (lsr_read) m_ovr = 0;
        end
        m_trig = m_rcnt >= lvl[rx_trig_sel];
        #1;
    endtask

    task automatic test_reset();
        idle();
        rx_trig_sel = 2'd0;
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;
        model_zero();
        #1;
        n_checks++; if (tx_fifo_ptr !== 5'd0 || rx_fifo_ptr !== 5'd0) begin n_fail++; $display("FAIL reset_counts got tx=%0d rx=%0d exp 0/0", tx_fifo_ptr, rx_fifo_ptr); end
        n_checks++; if ({tx_empty, rx_empty, tx_full, rx_full} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags got %b exp 1100", {tx_empty, rx_empty, tx_full, rx_full}); end
        n_checks++; if ({tx_wr_addr, tx_rd_addr, rx_wr_addr, rx_rd_addr} !== 16'h0) begin n_fail++; $display("FAIL reset_addrs got %h exp 0000", {tx_wr_addr, tx_rd_addr, rx_wr_addr, rx_rd_addr}); end
        n_checks++; if ({rx_overrun, rx_trig, char_timeout, tx_wr_en, rx_wr_en} !== 5'b0) begin n_fail++; $display("FAIL reset_status got %b exp 00000", {rx_overrun, rx_trig, char_timeout, tx_wr_en, rx_wr_en}); end
    endtask

    task automatic test_tx_fill();
        idle();
        for (int i = 0; i < D; i++) begin
            tx_push = 1;
            #1;
            n_checks++; if (tx_wr_en !== 1'b1 || tx_wr_addr !== 4'(i)) begin n_fail++; $display("FAIL tx_fill_wr got en=%0b addr=%0d exp en=1 addr=%0d", tx_wr_en, tx_wr_addr, i); end
            tick();
        end
        n_checks++; if (tx_fifo_ptr !== 5'd16 || tx_full !== 1'b1) begin n_fail++; $display("FAIL tx_full got cnt=%0d full=%0b exp 16/1", tx_fifo_ptr, tx_full); end
        tx_push = 1;
        #1;
        n_checks++; if (tx_wr_en !== 1'b0) begin n_fail++; $display("FAIL tx_push_when_full got wr_en=%0b exp 0", tx_wr_en); end
        tick();
        n_checks++; if (tx_fifo_ptr !== 5'd16) begin n_fail++; $display("FAIL tx_cnt_after_drop got %0d exp 16", tx_fifo_ptr); end
    endtask

    task automatic test_tx_push_pop_full();
        idle();
        tx_push = 1; tx_pop = 1;
        #1;
        n_checks++; if (tx_wr_en !== 1'b1 || tx_wr_addr !== 4'd0) begin n_fail++; $display("FAIL tx_pp_wr got en=%0b addr=%0d exp 1/0", tx_wr_en, tx_wr_addr); end
        tick();
        n_checks++; if (tx_fifo_ptr !== 5'd16 || tx_wr_addr !== 4'd1 || tx_rd_addr !== 4'd1) begin n_fail++; $display("FAIL tx_pp_full got cnt=%0d wr=%0d rd=%0d exp 16/1/1", tx_fifo_ptr, tx_wr_addr, tx_rd_addr); end
        idle();
        tx_clr = 1; tx_push = 1;
        tick();
        n_checks++; if (tx_fifo_ptr !== 5'd0 || tx_empty !== 1'b1 || tx_wr_addr !== 4'd0) begin n_fail++; $display("FAIL tx_clr got cnt=%0d empty=%0b wr=%0d exp 0/1/0", tx_fifo_ptr, tx_empty, tx_wr_addr); end
    endtask

    task automatic test_tx_wrap();
        idle();
        for (int i = 0; i < 20; i++) begin
            tx_push = 1; tx_pop = 0;
            #1;
            n_checks++; if (tx_wr_addr !== 4'(m_tpushes % D)) begin n_fail++; $display("FAIL tx_wrap_wr got %0d exp %0d", tx_wr_addr, m_tpushes % D); end
            tick();
            tx_push = 0; tx_pop = 1;
            tick();
        end
        idle();
        n_checks++; if (tx_fifo_ptr !== 5'd0 || tx_empty !== 1'b1) begin n_fail++; $display("FAIL tx_wrap_empty got cnt=%0d empty=%0b exp 0/1", tx_fifo_ptr, tx_empty); end
        n_checks++; if (tx_wr_addr !== 4'd4 || tx_rd_addr !== 4'd4) begin n_fail++; $display("FAIL tx_wrap_ptrs got wr=%0d rd=%0d exp 4/4", tx_wr_addr, tx_rd_addr); end
    endtask

    task automatic test_rx_overrun();
        idle();
        rx_clr = 1; tick(); idle();
        rx_push = 1;
        repeat (D) tick();
        #1;
        n_checks++; if (rx_wr_en !== 1'b0 || rx_full !== 1'b1) begin n_fail++; $display("FAIL rx_full_wr got en=%0b full=%0b exp 0/1", rx_wr_en, rx_full); end
        tick();
        n_checks++; if (rx_overrun !== 1'b1 || rx_fifo_ptr !== 5'd16) begin n_fail++; $display("FAIL rx_overrun_set got ovr=%0b cnt=%0d exp 1/16", rx_overrun, rx_fifo_ptr); end
        lsr_read = 1;
        tick();
        n_checks++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL rx_overrun_set_prio got %0b exp 1", rx_overrun); end
        rx_push = 0;
        tick();
        n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL rx_overrun_lsr_clr got %0b exp 0", rx_overrun); end
        idle();
    endtask

    task automatic test_rx_trig();
        idle();
        rx_trig_sel = 2'd2;
        rx_clr = 1; tick(); idle();
        rx_push = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++; if (rx_trig !== (i >= 8)) begin n_fail++; $display("FAIL rx_trig_lvl8 push=%0d got %0b exp %0b", i, rx_trig, i >= 8); end
        end
        idle();
        rx_trig_sel = 2'd3;
        tick();
        n_checks++; if (rx_trig !== 1'b0) begin n_fail++; $display("FAIL rx_trig_sel14 got %0b exp 0", rx_trig); end
    endtask

    task automatic test_timeout();
        idle();
        rx_clr = 1; tick(); idle();
        rx_push = 1;
        repeat (3) tick();
        idle();
        tick();
        for (int i = 1; i <= 4; i++) begin
            char_tick = 1;
            tick();
            char_tick = 0;
            tick();
            n_checks++; if (char_timeout !== (i == 4)) begin n_fail++; $display("FAIL char_timeout tick=%0d got %0b exp %0b", i, char_timeout, i == 4); end
        end
        rx_pop = 1;
        tick();
        idle();
        n_checks++; if (char_timeout !== 1'b0 || rx_fifo_ptr !== 5'd2) begin n_fail++; $display("FAIL timeout_pop got to=%0b cnt=%0d exp 0/2", char_timeout, rx_fifo_ptr); end
        rx_clr = 1; rx_push = 1;
        #1;
        n_checks++; if (rx_wr_en !== 1'b0) begin n_fail++; $display("FAIL rx_clr_push_wr got %0b exp 0", rx_wr_en); end
        tick();
        idle();
        n_checks++; if (rx_fifo_ptr !== 5'd0 || rx_empty !== 1'b1) begin n_fail++; $display("FAIL rx_clr_push got cnt=%0d empty=%0b exp 0/1", rx_fifo_ptr, rx_empty); end
    endtask

    task automatic test_random();
        int pp;
        for (int c = 0; c < 600; c++) begin
            pp = (c % 200) < 100 ? 80 : 25;
            tx_push   = ($urandom_range(0, 99) < pp);
            rx_push   = ($urandom_range(0, 99) < pp);
            tx_pop    = ($urandom_range(0, 99) < 100 - pp);
            rx_pop    = ($urandom_range(0, 99) < 100 - pp);
            tx_clr    = ($urandom_range(0, 63) == 0);
            rx_clr    = ($urandom_range(0, 63) == 0);
            lsr_read  = ($urandom_range(0, 7) == 0);
            char_tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) rx_trig_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                tx_push = 0; rx_push = 0; tx_pop = 0; rx_pop = 0;
            end
            #1;
            n_checks++; if (tx_wr_en !== tx_push_acc() || rx_wr_en !== rx_push_acc()) begin n_fail++; $display("FAIL rnd_wr_en c=%0d got %0b%0b exp %0b%0b", c, tx_wr_en, rx_wr_en, tx_push_acc(), rx_push_acc()); end
            tick();
            n_checks++; if (tx_fifo_ptr !== 5'(m_tcnt) || rx_fifo_ptr !== 5'(m_rcnt)) begin n_fail++; $display("FAIL rnd_counts c=%0d got %0d/%0d exp %0d/%0d", c, tx_fifo_ptr, rx_fifo_ptr, m_tcnt, m_rcnt); end
            n_checks++; if (tx_wr_addr !== 4'(m_tpushes % D) || tx_rd_addr !== 4'(m_tpops % D) || rx_wr_addr !== 4'(m_rpushes % D) || rx_rd_addr !== 4'(m_rpops % D)) begin n_fail++; $display("FAIL rnd_addrs c=%0d got %0d %0d %0d %0d", c, tx_wr_addr, tx_rd_addr, rx_wr_addr, rx_rd_addr); end
            n_checks++; if ({tx_full, tx_empty, rx_full, rx_empty} !== {m_tcnt == D, m_tcnt == 0, m_rcnt == D, m_rcnt == 0}) begin n_fail++; $display("FAIL rnd_flags c=%0d got %b", c, {tx_full, tx_empty, rx_full, rx_empty}); end
            n_checks++; if (rx_overrun !== m_ovr || rx_trig !== m_trig) begin n_fail++; $display("FAIL rnd_ovr_trig c=%0d got %0b%0b exp %0b%0b", c, rx_overrun, rx_trig, m_ovr, m_trig); end
            n_checks++; if (char_timeout !== (m_idle == 4 && m_rcnt != 0)) begin n_fail++; $display("FAIL rnd_timeout c=%0d got %0b exp %0b", c, char_timeout, m_idle == 4 && m_rcnt != 0); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        tx_push = 1; rx_push = 1;
        repeat (5) tick();
        @(posedge clock);
        #3;
        idle();
        reset_n = 0;
        #1;
        n_checks++; if (tx_fifo_ptr !== 5'd0 || rx_fifo_ptr !== 5'd0 || tx_wr_addr !== 4'd0 || rx_wr_addr !== 4'd0) begin n_fail++; $display("FAIL mid_reset_ptrs got %0d %0d %0d %0d exp 0", tx_fifo_ptr, rx_fifo_ptr, tx_wr_addr, rx_wr_addr); end
        n_checks++; if ({tx_empty, rx_empty, tx_full, rx_full, rx_overrun, rx_trig, char_timeout, tx_wr_en, rx_wr_en} !== 9'b110000000) begin n_fail++; $display("FAIL mid_reset_flags got %b exp 110000000", {tx_empty, rx_empty, tx_full, rx_full, rx_overrun, rx_trig, char_timeout, tx_wr_en, rx_wr_en}); end
        @(posedge clock);
        #1;
        reset_n = 1;
        model_zero();
    endtask

    initial begin
        test_reset();
        test_tx_fill();
        test_tx_push_pop_full();
        test_tx_wrap();
        test_rx_overrun();
        test_rx_trig();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
